// File: rtl/vscale_fetch_queue_if.sv
// vscale fetch queue port bundle
// imem request/response, redirect and dequeue handshake
interface vscale_fetch_queue_if #(
  parameter int XPR_LEN = 32,
  parameter int DEPTH   = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic               redirect;
  logic [XPR_LEN-1:0] redirect_PC;
  logic               imem_wait;
  logic [XPR_LEN-1:0] imem_addr;
  logic [31:0]        imem_rdata;
  logic               imem_badmem_e;
  logic               deq_ready;
  logic               deq_valid;
  logic [31:0]        deq_inst;
  logic [XPR_LEN-1:0] deq_PC;
  logic               deq_badmem;
  logic [CW-1:0]      count;

  modport master (
    input  redirect,
    input  redirect_PC,
    input  imem_wait,
    input  imem_rdata,
    input  imem_badmem_e,
    input  deq_ready,
    output imem_addr,
    output deq_valid,
    output deq_inst,
    output deq_PC,
    output deq_badmem,
    output count
  );

  modport slave (
    output redirect,
    output redirect_PC,
    output imem_wait,
    output imem_rdata,
    output imem_badmem_e,
    output deq_ready,
    input  imem_addr,
    input  deq_valid,
    input  deq_inst,
    input  deq_PC,
    input  deq_badmem,
    input  count
  );
endinterface

// File: rtl/vscale_fetch_queue.sv
// vscale fetch queue: fetch PC, imem port, DEPTH-entry prefetch buffer
// VSCALE_FETCHQ_BYPASS_EN: empty-queue responses shown on deq_* same cycle
module vscale_fetch_queue #(
  parameter int                 XPR_LEN  = 32,
  parameter int                 DEPTH    = 4,
  parameter logic [XPR_LEN-1:0] RESET_PC = XPR_LEN'(32'h200)
) (
  input  logic                  clk,
  input  logic                  reset,
  vscale_fetch_queue_if.master  fq
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);
  localparam logic [31:0] RV_NOP  = 32'h0000_0013;

  logic [XPR_LEN-1:0] r_fetch_pc;
  logic [XPR_LEN-1:0] r_req_pc;
  logic               r_resp_pending;
  logic               r_stale;
  logic               r_halted;
  logic [AW-1:0]      r_head;
  logic [AW-1:0]      r_tail;
  logic [CW-1:0]      r_count;

  logic [31:0]        r_inst [DEPTH];
  logic [XPR_LEN-1:0] r_pc   [DEPTH];
  logic               r_bad  [DEPTH];

  logic               w_resp_arrives;
  logic [CW:0]        w_occ;
  logic               w_issue;
  logic               w_enq;
  logic               w_byp;
  logic               w_nonempty;
  logic               w_push;
  logic               w_pop;
  logic [XPR_LEN-1:0] w_addr;

  assign w_addr = fq.redirect ? fq.redirect_PC : r_fetch_pc;
  assign fq.imem_addr = w_addr;

  assign w_resp_arrives = r_resp_pending & ~fq.imem_wait;
  assign w_nonempty = (r_count != '0);

  // occupancy counts the in-flight word so any arrival finds a free slot
  assign w_occ = {1'b0, r_count} + {{CW{1'b0}}, r_resp_pending};

  assign w_issue = ~fq.imem_wait & ~r_halted
                 & (~r_resp_pending | w_resp_arrives)
                 & (w_occ < DEPTH_W);

  assign w_enq = w_resp_arrives & ~r_stale & ~fq.redirect;

`ifdef VSCALE_FETCHQ_BYPASS_EN
  assign w_byp = w_enq & ~w_nonempty;
`else
  assign w_byp = 1'b0;
`endif

  assign w_pop  = w_nonempty & fq.deq_ready & ~fq.redirect;
  assign w_push = w_enq & ~(w_byp & fq.deq_ready);

  // head presentation, falling back to the bypassed word or a bubble
  always_comb begin
    fq.deq_valid  = w_nonempty | w_byp;
    fq.deq_inst   = RV_NOP;
    fq.deq_PC     = '0;
    fq.deq_badmem = 1'b0;
    if (w_nonempty) begin
      fq.deq_inst   = r_inst[r_head];
      fq.deq_PC     = r_pc[r_head];
      fq.deq_badmem = r_bad[r_head];
    end else if (w_byp) begin
      fq.deq_inst   = fq.imem_rdata;
      fq.deq_PC     = r_req_pc;
      fq.deq_badmem = fq.imem_badmem_e;
    end
  end

  assign fq.count = r_count;

  // fetch PC and outstanding-request tracking
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc     <= RESET_PC;
      r_req_pc       <= '0;
      r_resp_pending <= 1'b0;
    end else begin
      if (w_issue) begin
        r_fetch_pc <= w_addr + XPR_LEN'(4);
        r_req_pc   <= w_addr;
      end else if (fq.redirect) begin
        r_fetch_pc <= fq.redirect_PC;
      end
      if (w_issue)
        r_resp_pending <= 1'b1;
      else if (w_resp_arrives)
        r_resp_pending <= 1'b0;
    end
  end

  // stale marks a held response that a redirect has orphaned
  always_ff @(posedge clk) begin
    if (reset)
      r_stale <= 1'b0;
    else if (fq.redirect & r_resp_pending & fq.imem_wait)
      r_stale <= 1'b1;
    else if (w_resp_arrives)
      r_stale <= 1'b0;
  end

  // a faulting fetch stops issue until software redirects
  always_ff @(posedge clk) begin
    if (reset)
      r_halted <= 1'b0;
    else if (fq.redirect)
      r_halted <= 1'b0;
    else if (w_enq & fq.imem_badmem_e)
      r_halted <= 1'b1;
  end

  // pointers and occupancy; redirect flushes everything
  always_ff @(posedge clk) begin
    if (reset | fq.redirect) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push)
        r_tail <= r_tail + AW'(1);
      if (w_pop)
        r_head <= r_head + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // entry storage, validity is carried by the pointers
  always_ff @(posedge clk) begin
    if (w_push & ~reset) begin
      r_inst[r_tail] <= fq.imem_rdata;
      r_pc[r_tail]   <= r_req_pc;
      r_bad[r_tail]  <= fq.imem_badmem_e;
    end
  end

endmodule

// File: tb/tb_vscale_fetch_queue.sv
// vscale fetch queue bench
// per-cycle vector table against a tiny imem model
module tb_vscale_fetch_queue;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  vscale_fetch_queue_if #(.XPR_LEN(32), .DEPTH(4)) bus ();

  vscale_fetch_queue #(
    .XPR_LEN (32),
    .DEPTH   (4),
    .RESET_PC(32'h200)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .fq   (bus.master)
  );

  typedef struct {
    bit          rst;
    bit          chk;
    bit          redir;
    logic [31:0] rpc;
    bit          wt;
    bit          rdy;
    bit          arm;
    bit          ev;
    logic [31:0] epc;
    bit          ebad;
    logic [31:0] eaddr;
    int          ecnt;
  } vec_t;

  vec_t vecs[$];
  int n_chk = 0;
  int n_err = 0;
  logic [31:0] last_addr = 32'h0;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic vec_t mk_rst();
    vec_t v;
    v = '{rst: 1'b1, chk: 1'b0, redir: 1'b0, rpc: 32'h0,
          wt: 1'b0, rdy: 1'b0, arm: 1'b0, ev: 1'b0,
          epc: 32'h0, ebad: 1'b0, eaddr: 32'h0, ecnt: 0};
    return v;
  endfunction

  function automatic vec_t mk_c(bit wt, bit rdy, bit arm, bit ev,
                                logic [31:0] epc, bit ebad,
                                logic [31:0] eaddr, int ecnt);
    vec_t v;
    v = '{rst: 1'b0, chk: 1'b1, redir: 1'b0, rpc: 32'h0,
          wt: wt, rdy: rdy, arm: arm, ev: ev,
          epc: epc, ebad: ebad, eaddr: eaddr, ecnt: ecnt};
    return v;
  endfunction

  function automatic vec_t mk_r(logic [31:0] rpc, bit wt, bit rdy,
                                bit ev, logic [31:0] epc,
                                logic [31:0] eaddr, int ecnt);
    vec_t v;
    v = mk_c(wt, rdy, 1'b0, ev, epc, 1'b0, eaddr, ecnt);
    v.redir = 1'b1;
    v.rpc = rpc;
    return v;
  endfunction

  task automatic check(string nm, int idx,
                       logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s row %0d: got %h want %h", nm, idx, act, exp);
    end
  endtask

  task automatic step(input vec_t v, input int idx);
    logic [31:0] cur_addr;
    logic [31:0] e_inst;
    logic [31:0] e_pc;
    @(negedge clk);
    reset = v.rst;
    bus.redirect = v.redir;
    bus.redirect_PC = v.rpc;
    bus.imem_wait = v.wt;
    bus.deq_ready = v.rdy;
    bus.imem_rdata = mem_word(last_addr);
    bus.imem_badmem_e = v.arm && (last_addr == 32'h208);
    #1;
    if (v.chk) begin
      e_inst = v.ev ? mem_word(v.epc) : 32'h13;
      e_pc = v.ev ? v.epc : 32'h0;
      check("deq_valid", idx, 32'(bus.deq_valid), 32'(v.ev));
      check("deq_PC", idx, bus.deq_PC, e_pc);
      check("deq_inst", idx, bus.deq_inst, e_inst);
      check("deq_badmem", idx, 32'(bus.deq_badmem), 32'(v.ebad));
      check("imem_addr", idx, bus.imem_addr, v.eaddr);
      check("count", idx, 32'(bus.count), v.ecnt);
    end
    cur_addr = bus.imem_addr;
    @(posedge clk);
    if (!v.wt) last_addr = cur_addr;
  endtask

  initial begin
    vec_t v;
    bus.redirect = 1'b0;
    bus.redirect_PC = 32'h0;
    bus.imem_wait = 1'b0;
    bus.imem_rdata = 32'h0;
    bus.imem_badmem_e = 1'b0;
    bus.deq_ready = 1'b0;

    // streaming
    vecs.push_back(mk_rst());
    vecs.push_back(mk_c(0, 1, 0, 0, 32'h0,   0, 32'h200, 0));
    vecs.push_back(mk_c(0, 1, 0, 0, 32'h0,   0, 32'h204, 0));
    vecs.push_back(mk_c(0, 1, 0, 1, 32'h200, 0, 32'h208, 1));
    vecs.push_back(mk_c(0, 1, 0, 1, 32'h204, 0, 32'h20C, 1));
    vecs.push_back(mk_c(0, 1, 0, 1, 32'h208, 0, 32'h210, 1));
    vecs.push_back(mk_c(0, 1, 0, 1, 32'h20C, 0, 32'h214, 1));
    // backpressure then drain
    vecs.push_back(mk_rst());
    vecs.push_back(mk_c(0, 0, 0, 0, 32'h0,   0, 32'h200, 0));
    vecs.push_back(mk_c(0, 0, 0, 0, 32'h0,   0, 32'h204, 0));
    vecs.push_back(mk_c(0, 0, 0, 1, 32'h200, 0, 32'h208, 1));
    vecs.push_back(mk_c(0, 0, 0, 1, 32'h200, 0, 32'h20C, 2));
    vecs.push_back(mk_c(0, 0, 0, 1, 32'h200, 0, 32'h210, 3));
    vecs.push_back(mk_c(0, 0, 0, 1, 32'h200, 0, 32'h210, 4));
    vecs.push_back(mk_c(0, 0, 0, 1, 32'h200, 0, 32'h210, 4));
    vecs.push_back(mk_c(0, 1, 0, 1, 32'h200, 0, 32'h210, 4));
    vecs.push_back(mk_c(0, 1, 0, 1, 32'h204, 0, 32'h210, 3));
    vecs.push_back(mk_c(0, 1, 0, 1, 32'h208, 0, 32'h214, 2));
    vecs.push_back(mk_c(0, 1, 0, 1, 32'h20C, 0, 32'h218, 2));
    vecs.push_back(mk_c(0, 1, 0, 1, 32'h210, 0, 32'h21C, 2));
    vecs.push_back(mk_c(0, 1, 0, 1, 32'h214, 0, 32'h220, 2));
    vecs.push_back(mk_c(0, 1, 0, 1, 32'h218, 0, 32'h224, 2));
    // imem_wait holds a pending response
    vecs.push_back(mk_rst());
    vecs.push_back(mk_c(0, 1, 0, 0, 32'h0,   0, 32'h200, 0));
    vecs.push_back(mk_c(1, 1, 0, 0, 32'h0,   0, 32'h204, 0));
    vecs.push_back(mk_c(1, 1, 0, 0, 32'h0,   0, 32'h204, 0));
    vecs.push_back(mk_c(1, 1, 0, 0, 32'h0,   0, 32'h204, 0));
    vecs.push_back(mk_c(0, 1, 0, 0, 32'h0,   0, 32'h204, 0));
    vecs.push_back(mk_c(0, 1, 0, 1, 32'h200, 0, 32'h208, 1));
    vecs.push_back(mk_c(0, 1, 0, 1, 32'h204, 0, 32'h20C, 1));
    // redirect with 3 entries and a held response
    vecs.push_back(mk_rst());
    vecs.push_back(mk_c(0, 0, 0, 0, 32'h0,   0, 32'h200, 0));
    vecs.push_back(mk_c(0, 0, 0, 0, 32'h0,   0, 32'h204, 0));
    vecs.push_back(mk_c(0, 0, 0, 1, 32'h200, 0, 32'h208, 1));
    vecs.push_back(mk_c(0, 0, 0, 1, 32'h200, 0, 32'h20C, 2));
    vecs.push_back(mk_c(1, 0, 0, 1, 32'h200, 0, 32'h210, 3));
    vecs.push_back(mk_r(32'h400, 1, 0, 1, 32'h200, 32'h400, 3));
    vecs.push_back(mk_c(1, 0, 0, 0, 32'h0,   0, 32'h400, 0));
    vecs.push_back(mk_c(0, 1, 0, 0, 32'h0,   0, 32'h400, 0));
    vecs.push_back(mk_c(0, 1, 0, 0, 32'h0,   0, 32'h404, 0));
    vecs.push_back(mk_c(0, 1, 0, 1, 32'h400, 0, 32'h408, 1));
    // fetch fault at 0x208, halt, redirect to 0x100
    vecs.push_back(mk_rst());
    vecs.push_back(mk_c(0, 1, 1, 0, 32'h0,   0, 32'h200, 0));
    vecs.push_back(mk_c(0, 1, 1, 0, 32'h0,   0, 32'h204, 0));
    vecs.push_back(mk_c(0, 1, 1, 1, 32'h200, 0, 32'h208, 1));
    vecs.push_back(mk_c(0, 1, 1, 1, 32'h204, 0, 32'h20C, 1));
    vecs.push_back(mk_c(0, 1, 1, 1, 32'h208, 1, 32'h210, 1));
    vecs.push_back(mk_c(0, 1, 1, 1, 32'h20C, 0, 32'h210, 1));
    vecs.push_back(mk_c(0, 1, 1, 0, 32'h0,   0, 32'h210, 0));
    vecs.push_back(mk_c(0, 1, 1, 0, 32'h0,   0, 32'h210, 0));
    vecs.push_back(mk_r(32'h100, 0, 1, 0, 32'h0, 32'h100, 0));
    vecs.push_back(mk_c(0, 1, 0, 0, 32'h0,   0, 32'h100, 0));
    vecs.push_back(mk_c(0, 1, 0, 0, 32'h0,   0, 32'h104, 0));
    vecs.push_back(mk_c(0, 1, 0, 1, 32'h100, 0, 32'h108, 1));
    // PC wrap at the top of the address space
    vecs.push_back(mk_rst());
    vecs.push_back(mk_r(32'hFFFF_FFFC, 0, 1, 0, 32'h0, 32'hFFFF_FFFC, 0));
    vecs.push_back(mk_c(0, 1, 0, 0, 32'h0,        0, 32'h0, 0));
    vecs.push_back(mk_c(0, 1, 0, 1, 32'hFFFF_FFFC, 0, 32'h4, 1));
    vecs.push_back(mk_c(0, 1, 0, 1, 32'h0,        0, 32'h8, 1));
    // redirect in the arrival cycle drops the word
    vecs.push_back(mk_rst());
    vecs.push_back(mk_c(0, 1, 0, 0, 32'h0,   0, 32'h200, 0));
    vecs.push_back(mk_r(32'h300, 0, 1, 0, 32'h0, 32'h300, 0));
    vecs.push_back(mk_c(0, 1, 0, 0, 32'h0,   0, 32'h304, 0));
    vecs.push_back(mk_c(0, 1, 0, 1, 32'h300, 0, 32'h308, 1));

    foreach (vecs[i]) step(vecs[i], i);

    // reset in the middle of a held response
    step(mk_rst(), 1000);
    step(mk_c(0, 0, 0, 0, 32'h0,   0, 32'h200, 0), 1001);
    step(mk_c(0, 0, 0, 0, 32'h0,   0, 32'h204, 0), 1002);
    step(mk_c(1, 0, 0, 1, 32'h200, 0, 32'h208, 1), 1003);
    v = mk_rst();
    v.wt = 1'b1;
    step(v, 1004);
    step(mk_c(0, 1, 0, 0, 32'h0,   0, 32'h200, 0), 1005);
    step(mk_c(0, 1, 0, 0, 32'h0,   0, 32'h204, 0), 1006);
    step(mk_c(0, 1, 0, 1, 32'h200, 0, 32'h208, 1), 1007);
    step(mk_c(0, 1, 0, 1, 32'h204, 0, 32'h20C, 1), 1008);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
